// File: rtl/de1_out_stream_if.sv
// rtl/de1_out_stream_if.sv - slave-FIFO read bus plus playback stream bundle for de1_out_stream
//
// Groups the USB slave-FIFO pins used by the OUT-endpoint reader together
// with the valid/ready stream handed to the DAC/playback path.
//   flaga     : OUT-endpoint partial flag, 1 = data available
//   fdata_in  : 16-bit slave-FIFO data bus
//   faddr     : FIFO address
//   sloe/slrd : output enable / read strobe, both active low
//   slwr      : write strobe, held inactive (1)
//   pkt_end   : packet end, held inactive (1)
//   m_data    : stream head word
//   m_valid   : stream word present
//   m_ready   : consumer accepts the head word
// master = the reader block, slave = the USB chip / consumer side.

interface de1_out_stream_if;
    logic        flaga;
    logic [15:0] fdata_in;
    logic [1:0]  faddr;
    logic        sloe;
    logic        slrd;
    logic        slwr;
    logic        pkt_end;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;

    modport master (
        input  flaga,
        input  fdata_in,
        input  m_ready,
        output faddr,
        output sloe,
        output slrd,
        output slwr,
        output pkt_end,
        output m_data,
        output m_valid
    );

    modport slave (
        output flaga,
        output fdata_in,
        output m_ready,
        input  faddr,
        input  sloe,
        input  slrd,
        input  slwr,
        input  pkt_end,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/de1_out_stream.sv
// rtl/de1_out_stream.sv - USB slave-FIFO OUT-endpoint reader with credit-controlled show-ahead buffer
//
// Pulls 16-bit words from the host OUT endpoint with registered sloe/slrd
// strobes, tracks reads still travelling through the bus latency, and lands
// them in a DEPTH-word show-ahead FIFO that drives a valid/ready stream.
// Ports:
//   clk_out_0  : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : 1 = may start/continue reading
//   bus        : slave-FIFO pins and playback stream (master modport)
//   word_count : words captured since reset, wraps modulo 2^32
//   overflow   : sticky, a capture found the buffer full
//   busy       : 1 whenever the reader is not idle

module de1_out_stream #(
    parameter int         DEPTH      = 8,
    parameter int         RD_LATENCY = 2,
    parameter logic [1:0] EP_ADDR    = 2'b00
) (
    input  logic                    clk_out_0,
    input  logic                    reset_n,
    input  logic                    enable,
    de1_out_stream_if.master        bus,
    output logic [31:0]             word_count,
    output logic                    overflow,
    output logic                    busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state;
    logic                   sloe_r;
    logic                   slrd_r;

    // One tag per cycle the read strobe was sampled low; the oldest stage
    // lines up with the cycle its data is valid on fdata_in.
    logic [RD_LATENCY-1:0]  pipe;
    logic [RD_LATENCY-1:0]  pipe_next;

    logic [15:0]            mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            fill;

    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic [31:0]            inflight;
    logic                   can_read;

    assign bus.faddr   = EP_ADDR;
    assign bus.slwr    = 1'b1;
    assign bus.pkt_end = 1'b1;
    assign bus.sloe    = sloe_r;
    assign bus.slrd    = slrd_r;
    assign bus.m_data  = mem[rd_ptr];
    assign bus.m_valid = (fill != '0);

    always_comb begin
        pipe_next    = '0;
        pipe_next[0] = ~slrd_r;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_next[i] = pipe[i-1];
        end
    end

    // Outstanding words include the strobe currently on the pins: it is
    // already committed and will be sampled at the coming edge, so it must
    // hold a buffer slot before another read is granted.
    always_comb begin
        inflight = {31'd0, ~slrd_r};
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {31'd0, pipe[i]};
        end
    end

    assign can_read = bus.flaga & enable & ((32'(fill) + inflight) < 32'(DEPTH));

    assign push  = pipe[RD_LATENCY-1];
    assign pop   = bus.m_valid & bus.m_ready;
    assign full  = (fill == (AW+1)'(DEPTH));
    // A pop in the same cycle frees the head slot, so a full buffer can
    // still accept the incoming word.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk_out_0 or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            sloe_r <= 1'b1;
            slrd_r <= 1'b1;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sloe_r <= 1'b1;
                    slrd_r <= 1'b1;
                    if (enable && bus.flaga) begin
                        state  <= SETUP;
                        sloe_r <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                SETUP: begin
                    // Output enable has had one full cycle; the first strobe
                    // may go out on the same edge that enters READ.
                    state  <= READ;
                    slrd_r <= ~can_read;
                end
                READ: begin
                    if (!bus.flaga || !enable) begin
                        state  <= DRAIN;
                        slrd_r <= 1'b1;
                    end else begin
                        slrd_r <= ~can_read;
                    end
                end
                DRAIN: begin
                    slrd_r <= 1'b1;
                    if (pipe == '0 && slrd_r) begin
                        state  <= IDLE;
                        sloe_r <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    sloe_r <= 1'b1;
                    slrd_r <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_out_0 or negedge reset_n) begin
        if (!reset_n) begin
            pipe <= '0;
        end else begin
            pipe <= pipe_next;
        end
    end

    always_ff @(posedge clk_out_0 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= bus.fdata_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (push) begin
                word_count <= word_count + 32'd1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_de1_out_stream.sv
// tb/tb_de1_out_stream.sv - self-checking bench for de1_out_stream

module tb_de1_out_stream;

    localparam int DEPTH = 8;
    localparam int RDL   = 2;

    logic        clk_out_0 = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic [31:0] word_count;
    logic        overflow;
    logic        busy;

    de1_out_stream_if bus ();

    de1_out_stream #(
        .DEPTH      (DEPTH),
        .RD_LATENCY (RDL),
        .EP_ADDR    (2'b00)
    ) dut (
        .clk_out_0  (clk_out_0),
        .reset_n    (reset_n),
        .enable     (enable),
        .bus        (bus.master),
        .word_count (word_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk_out_0 = ~clk_out_0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // USB chip + consumer model, evaluated mid-cycle. A low strobe seen here
    // is sampled at the next edge; its word is placed on the bus so that it
    // is valid RDL edges later. Every issued word joins the expected queue.
    logic [15:0] word_base = 16'h0000;
    logic [15:0] next_word;
    logic        s0_v, s1_v;
    logic [15:0] s0_w, s1_w;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          reads;
    int          mfill;
    bit          pend_cap, pend_pop;

    always @(negedge clk_out_0) begin
        if (!reset_n) begin
            next_word    = word_base;
            s0_v         = 1'b0;
            s1_v         = 1'b0;
            s0_w         = '0;
            s1_w         = '0;
            reads        = 0;
            mfill        = 0;
            pend_cap     = 1'b0;
            pend_pop     = 1'b0;
            exp_q.delete();
            got_q.delete();
            bus.fdata_in = 16'($urandom);
        end else begin
            mfill = mfill + int'(pend_cap) - int'(pend_pop);
            check("m_valid vs model fill", 32'(bus.m_valid), 32'(mfill != 0));
            check("fill bound", 32'(mfill <= DEPTH), 32'd1);
            check("overflow clear", 32'(overflow), 32'd0);
            pend_pop = bus.m_valid && bus.m_ready;
            if (pend_pop) begin
                if (exp_q.size() == 0) begin
                    check("stream word without read", 32'(bus.m_data), 32'hFFFF_FFFF);
                end else begin
                    check("stream data order", 32'(bus.m_data), 32'(exp_q.pop_front()));
                end
                got_q.push_back(bus.m_data);
            end
            pend_cap     = s1_v;
            bus.fdata_in = s1_v ? s1_w : 16'($urandom);
            s1_v         = s0_v;
            s1_w         = s0_w;
            s0_v         = !bus.slrd;
            if (s0_v) begin
                s0_w = next_word;
                exp_q.push_back(next_word);
                next_word = next_word + 16'd1;
                reads++;
            end
        end
    end

    task automatic do_reset(input logic [15:0] base);
        reset_n     = 1'b0;
        word_base   = base;
        enable      = 1'b0;
        bus.flaga   = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk_out_0);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        int g;
        g = 0;
        @(posedge clk_out_0);
        #2;
        while (busy && g < bound) begin
            @(posedge clk_out_0);
            #2;
            g++;
        end
        check("idle reached", 32'(busy), 32'd0);
    endtask

    task automatic run_reads(input int n, input bit drop_enable);
        int cnt, g;
        cnt = 0;
        g   = 0;
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        bus.flaga   = 1'b1;
        while (cnt < n && g < 200) begin
            @(posedge clk_out_0);
            #2;
            if (!bus.slrd) cnt++;
            g++;
        end
        check("reads issued before stop", 32'(cnt), 32'(n));
        if (drop_enable) enable = 1'b0;
        else bus.flaga = 1'b0;
        wait_idle(200);
        repeat (3) @(posedge clk_out_0);
        #2;
    endtask

    typedef struct {
        logic en;
        logic fl;
        int   cyc;
        int   exp_reads;
        logic exp_busy;
    } idle_vec_t;

    idle_vec_t tbl[3];

    initial begin
        int r0, oe_lo, g;

        tbl[0] = '{en: 1'b1, fl: 1'b0, cyc: 50, exp_reads: 0, exp_busy: 1'b0};
        tbl[1] = '{en: 1'b0, fl: 1'b1, cyc: 30, exp_reads: 0, exp_busy: 1'b0};
        tbl[2] = '{en: 1'b0, fl: 1'b0, cyc: 10, exp_reads: 0, exp_busy: 1'b0};

        // Reset held with the bus asking to start
        reset_n     = 1'b0;
        enable      = 1'b1;
        bus.flaga   = 1'b1;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk_out_0);
        #2;
        check("reset sloe", 32'(bus.sloe), 32'd1);
        check("reset slrd", 32'(bus.slrd), 32'd1);
        check("reset m_valid", 32'(bus.m_valid), 32'd0);
        check("reset m_data", 32'(bus.m_data), 32'd0);
        check("reset word_count", word_count, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("faddr", 32'(bus.faddr), 32'd0);
        check("slwr", 32'(bus.slwr), 32'd1);
        check("pkt_end", 32'(bus.pkt_end), 32'd1);

        // Conditions that must never start a read
        do_reset(16'h0000);
        for (int i = 0; i < 3; i++) begin
            enable    = tbl[i].en;
            bus.flaga = tbl[i].fl;
            r0        = reads;
            oe_lo     = 0;
            for (int c = 0; c < tbl[i].cyc; c++) begin
                @(posedge clk_out_0);
                #2;
                if (!bus.sloe) oe_lo++;
            end
            check($sformatf("vec%0d reads", i), 32'(reads - r0), 32'(tbl[i].exp_reads));
            check($sformatf("vec%0d sloe low cycles", i), 32'(oe_lo), 32'd0);
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            check($sformatf("vec%0d word_count", i), word_count, 32'd0);
        end

        // Five-word burst, data 0x0001..0x0005
        do_reset(16'h0001);
        run_reads(5, 1'b0);
        check("burst reads", 32'(reads), 32'd5);
        check("burst word_count", word_count, 32'd5);
        check("burst words out", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) check($sformatf("burst word %0d", i), 32'(got_q[i]), 32'(i + 1));
        end
        check("burst sloe idle", 32'(bus.sloe), 32'd1);

        // Enable dropped after ten strobes: in-flight words still land
        do_reset(16'h0040);
        run_reads(10, 1'b1);
        check("enable drop reads", 32'(reads), 32'd10);
        check("enable drop word_count", word_count, 32'd10);
        check("enable drop words out", 32'(got_q.size()), 32'd10);
        check("enable drop sloe", 32'(bus.sloe), 32'd1);

        // Backpressure: credit stops at DEPTH outstanding words
        do_reset(16'h0100);
        enable    = 1'b1;
        bus.flaga = 1'b1;
        repeat (40) @(posedge clk_out_0);
        #2;
        check("bp reads", 32'(reads), 32'(DEPTH));
        check("bp word_count", word_count, 32'(DEPTH));
        check("bp slrd held", 32'(bus.slrd), 32'd1);
        check("bp m_valid", 32'(bus.m_valid), 32'd1);
        check("bp busy", 32'(busy), 32'd1);
        check("bp head", 32'(bus.m_data), 32'h0100);
        bus.m_ready = 1'b1;
        repeat (40) @(posedge clk_out_0);
        #2;
        check("bp resumed", 32'(reads > DEPTH + 20), 32'd1);
        bus.flaga = 1'b0;
        wait_idle(200);
        repeat (3) @(posedge clk_out_0);
        #2;
        check("bp total", word_count, 32'(reads));
        check("bp all out", 32'(got_q.size()), 32'(reads));

        // Asynchronous reset in the middle of a stalled burst
        do_reset(16'h0200);
        enable    = 1'b1;
        bus.flaga = 1'b1;
        g = 0;
        while (word_count != 32'd4 && g < 100) begin
            @(posedge clk_out_0);
            #2;
            g++;
        end
        check("mid reset reached 4", word_count, 32'd4);
        word_base = 16'h8000;
        reset_n   = 1'b0;
        #1;
        check("mid reset m_valid", 32'(bus.m_valid), 32'd0);
        check("mid reset word_count", word_count, 32'd0);
        check("mid reset slrd", 32'(bus.slrd), 32'd1);
        check("mid reset sloe", 32'(bus.sloe), 32'd1);
        check("mid reset busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk_out_0);
        #2;
        reset_n     = 1'b1;
        bus.m_ready = 1'b1;
        g = 0;
        while (!bus.m_valid && g < 50) begin
            @(posedge clk_out_0);
            #2;
            g++;
        end
        check("post reset first word", 32'(bus.m_data), 32'h8000);
        bus.flaga = 1'b0;
        wait_idle(200);
        repeat (3) @(posedge clk_out_0);
        #2;
        check("post reset total", word_count, 32'(reads));

        // Randomized flag/enable/ready traffic
        do_reset(16'h4000);
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk_out_0);
            #2;
            enable      = ($urandom_range(0, 9) != 0);
            bus.flaga   = ($urandom_range(0, 3) != 0);
            bus.m_ready = 1'($urandom_range(0, 1));
        end
        bus.flaga   = 1'b0;
        bus.m_ready = 1'b1;
        wait_idle(200);
        repeat (DEPTH + 4) @(posedge clk_out_0);
        #2;
        check("random total", word_count, 32'(reads));
        check("random all out", 32'(got_q.size()), 32'(reads));
        check("random queue empty", 32'(exp_q.size()), 32'd0);
        check("random some traffic", 32'(reads > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
